// File: rtl/corelet_seq.sv
// Corelet job sequencer: fetches weights and activations from SRAM into L0/IFIFO,
// then drives kernel-load, execute and OFIFO read-out phases for WS or OS dataflow.
module corelet_seq #(
  parameter int          row    = 8,
  parameter int          col    = 8,
  parameter int          len_bw = 5,
  parameter logic [10:0] W_BASE = 11'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [len_bw-1:0] num_act,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [34:0]       inst,
  output logic [10:0]       xmem_addr,
  output logic              xmem_cen,
  output logic              busy,
  output logic              done
);

  localparam int AMAX = (1 << len_bw) - 1;
  localparam int RC   = (row > col) ? row : col;
  localparam int MAXV = (RC > AMAX) ? RC : AMAX;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [3:0] {
    IDLE, W_LOAD, W_PUSH, W_GAP, A_LOAD, A_EXEC, DRAIN, READ, DONE
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                mode_q, mode_n;
  logic [len_bw-1:0]   n_q, n_n;
  logic [34:0]         inst_n;
  logic [10:0]         addr_n;
  logic                cen_n, busy_n, done_n;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mode_n     = mode_q;
    n_n        = n_q;
    inst_n     = '0;
    inst_n[34] = mode_q;
    addr_n     = xmem_addr;
    cen_n      = 1'b1;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        inst_n[34] = 1'b0;
        if (start && (num_act != '0)) begin
          state_n    = W_LOAD;
          mode_n     = mode;
          n_n        = num_act;
          cnt_n      = '0;
          busy_n     = 1'b1;
          inst_n[34] = mode;
        end
      end
      W_LOAD: begin
        if (!xmem_cen) begin
          if (mode_q) inst_n[4] = 1'b1;
          else        inst_n[2] = 1'b1;
        end
        if ((cnt == CW'(row)) && xmem_cen) begin
          cnt_n = '0;
          if (mode_q) begin
            state_n = A_LOAD;
          end else begin
            state_n     = W_PUSH;
            cnt_n       = CW'(1);
            inst_n[3]   = 1'b1;
            inst_n[1:0] = 2'b01;
          end
        end
      end
      W_PUSH: begin
        if (cnt == CW'(row)) begin
          state_n = W_GAP;
          cnt_n   = CW'(1);
        end else begin
          cnt_n       = cnt + 1'b1;
          inst_n[3]   = 1'b1;
          inst_n[1:0] = 2'b01;
        end
      end
      W_GAP: begin
        if (cnt == CW'(col)) begin
          state_n = A_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      A_LOAD: begin
        if (!xmem_cen) inst_n[2] = 1'b1;
        if ((cnt == CW'(n_q)) && xmem_cen) begin
          state_n     = A_EXEC;
          cnt_n       = CW'(1);
          inst_n[3]   = 1'b1;
          inst_n[1:0] = 2'b10;
          inst_n[5]   = mode_q;
        end
      end
      A_EXEC: begin
        if (cnt == CW'(n_q)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n       = cnt + 1'b1;
          inst_n[3]   = 1'b1;
          inst_n[1:0] = 2'b10;
          inst_n[5]   = mode_q;
        end
      end
      DRAIN: begin
        if (ofifo_valid) begin
          state_n    = READ;
          cnt_n      = CW'(1);
          inst_n[6]  = 1'b1;
          inst_n[33] = ~mode_q;
        end
      end
      READ: begin
        if (cnt == CW'(n_q)) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else if (ofifo_valid) begin
          cnt_n      = cnt + 1'b1;
          inst_n[6]  = 1'b1;
          inst_n[33] = ~mode_q;
        end
      end
      DONE: begin
        state_n    = IDLE;
        inst_n[34] = 1'b0;
        mode_n     = 1'b0;
        n_n        = '0;
        cnt_n      = '0;
      end
      default: state_n = IDLE;
    endcase

    // Read issue keys off the next state so each load phase fetches in its first cycle.
    if (!l0_full &&
        (((state_n == W_LOAD) && (cnt_n < CW'(row))) ||
         ((state_n == A_LOAD) && (cnt_n < CW'(n_n))))) begin
      cen_n  = 1'b0;
      addr_n = (state_n == W_LOAD) ? (W_BASE + 11'(cnt_n)) : 11'(cnt_n);
      cnt_n  = cnt_n + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      n_q       <= '0;
      inst      <= '0;
      xmem_addr <= '0;
      xmem_cen  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
      n_q       <= n_n;
      inst      <= inst_n;
      xmem_addr <= addr_n;
      xmem_cen  <= cen_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule
